// File: rtl/alu_exec_unit.sv
// Two-stage integer execution unit: S1 reads operands from the register file,
// S2 executes and holds the result on the CDB until the arbiter grants it.
module alu_exec_unit #(
  parameter int PREG_WIDTH = 7,
  parameter int ROB_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_issue_valid,
  input  logic [PREG_WIDTH-1:0] i_issue_prs1,
  input  logic [PREG_WIDTH-1:0] i_issue_prs2,
  input  logic [PREG_WIDTH-1:0] i_issue_prd,
  input  logic [ROB_WIDTH-1:0]  i_issue_rob_tag,
  input  logic [31:0]           i_issue_imm,
  input  logic [31:0]           i_issue_pc,
  input  logic [3:0]            i_issue_alu_op,
  input  logic                  i_issue_alusrc,
  output logic                  o_eu_ready,
  output logic [PREG_WIDTH-1:0] o_rf_raddr1,
  output logic [PREG_WIDTH-1:0] o_rf_raddr2,
  input  logic [31:0]           i_rf_rdata1,
  input  logic [31:0]           i_rf_rdata2,
  output logic                  o_cdb_req,
  output logic [PREG_WIDTH-1:0] o_cdb_prd,
  output logic [ROB_WIDTH-1:0]  o_cdb_rob_tag,
  output logic [31:0]           o_cdb_data,
  input  logic                  i_cdb_grant,
  input  logic                  branch_mispredict,
  input  logic [ROB_WIDTH-1:0]  mispredict_rob_tag,
  input  logic [ROB_WIDTH-1:0]  i_rob_head
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_LUI   = 4'd10;
  localparam logic [3:0] OP_AUIPC = 4'd11;
  localparam logic [3:0] OP_LINK  = 4'd12;

  // Ages are distances from the ROB head, so the comparison survives tag wrap.
  function automatic logic is_younger(input logic [ROB_WIDTH-1:0] tag,
                                      input logic [ROB_WIDTH-1:0] head,
                                      input logic [ROB_WIDTH-1:0] br);
    logic [ROB_WIDTH-1:0] tag_age;
    logic [ROB_WIDTH-1:0] br_age;
    tag_age = tag - head;
    br_age  = br - head;
    return tag_age > br_age;
  endfunction

  // S1 state
  logic                  s1_valid_q, s1_valid_d;
  logic [PREG_WIDTH-1:0] s1_prs1_q, s1_prs1_d;
  logic [PREG_WIDTH-1:0] s1_prs2_q, s1_prs2_d;
  logic [PREG_WIDTH-1:0] s1_prd_q, s1_prd_d;
  logic [ROB_WIDTH-1:0]  s1_tag_q, s1_tag_d;
  logic [31:0]           s1_imm_q, s1_imm_d;
  logic [31:0]           s1_pc_q, s1_pc_d;
  logic [3:0]            s1_alu_op_q, s1_alu_op_d;
  logic                  s1_alusrc_q, s1_alusrc_d;
  logic                  s1_captured_q, s1_captured_d;
  logic [31:0]           s1_rs1_q, s1_rs1_d;
  logic [31:0]           s1_rs2_q, s1_rs2_d;

  // S2 state
  logic                  s2_valid_q, s2_valid_d;
  logic [PREG_WIDTH-1:0] s2_prd_q, s2_prd_d;
  logic [ROB_WIDTH-1:0]  s2_tag_q, s2_tag_d;
  logic [31:0]           s2_result_q, s2_result_d;

  logic        s1_killed, s2_killed, issue_killed;
  logic        s2_free, s1_adv, eu_ready, issue_fire;
  logic [31:0] rs1_raw, rs2_raw, op_a, op_b, alu_result;

  assign s1_killed    = branch_mispredict & is_younger(s1_tag_q, i_rob_head, mispredict_rob_tag);
  assign s2_killed    = branch_mispredict & is_younger(s2_tag_q, i_rob_head, mispredict_rob_tag);
  assign issue_killed = branch_mispredict & is_younger(i_issue_rob_tag, i_rob_head, mispredict_rob_tag);

  assign s2_free    = !s2_valid_q | i_cdb_grant | s2_killed;
  assign s1_adv     = s1_valid_q & s2_free;
  assign eu_ready   = !s1_valid_q | s1_adv;
  assign issue_fire = i_issue_valid & eu_ready;

  assign o_eu_ready    = eu_ready;
  assign o_rf_raddr1   = i_issue_prs1;
  assign o_rf_raddr2   = i_issue_prs2;
  assign o_cdb_req     = s2_valid_q & !s2_killed;
  assign o_cdb_prd     = s2_prd_q;
  assign o_cdb_rob_tag = s2_tag_q;
  assign o_cdb_data    = s2_result_q;

  // The RF port is already re-addressed by the next issue, so a stalled op
  // must use its latched copy rather than the live read data.
  assign rs1_raw = s1_captured_q ? s1_rs1_q : i_rf_rdata1;
  assign rs2_raw = s1_captured_q ? s1_rs2_q : i_rf_rdata2;
  assign op_a    = (s1_prs1_q == '0) ? 32'd0 : rs1_raw;
  assign op_b    = s1_alusrc_q ? s1_imm_q : ((s1_prs2_q == '0) ? 32'd0 : rs2_raw);

  always_comb begin
    alu_result = 32'd0;
    case (s1_alu_op_q)
      OP_ADD:   alu_result = op_a + op_b;
      OP_SUB:   alu_result = op_a - op_b;
      OP_AND:   alu_result = op_a & op_b;
      OP_OR:    alu_result = op_a | op_b;
      OP_XOR:   alu_result = op_a ^ op_b;
      OP_SLL:   alu_result = op_a << op_b[4:0];
      OP_SRL:   alu_result = op_a >> op_b[4:0];
      OP_SRA:   alu_result = $unsigned($signed(op_a) >>> op_b[4:0]);
      OP_SLT:   alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
      OP_SLTU:  alu_result = {31'd0, op_a < op_b};
      OP_LUI:   alu_result = s1_imm_q;
      OP_AUIPC: alu_result = s1_pc_q + s1_imm_q;
      OP_LINK:  alu_result = s1_pc_q + 32'd4;
      default:  alu_result = 32'd0;
    endcase
  end

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_prs1_d     = s1_prs1_q;
    s1_prs2_d     = s1_prs2_q;
    s1_prd_d      = s1_prd_q;
    s1_tag_d      = s1_tag_q;
    s1_imm_d      = s1_imm_q;
    s1_pc_d       = s1_pc_q;
    s1_alu_op_d   = s1_alu_op_q;
    s1_alusrc_d   = s1_alusrc_q;
    s1_captured_d = s1_captured_q;
    s1_rs1_d      = s1_rs1_q;
    s1_rs2_d      = s1_rs2_q;
    if (issue_fire) begin
      // A wrong-path issue is still acknowledged but never becomes valid.
      s1_valid_d    = !issue_killed;
      s1_prs1_d     = i_issue_prs1;
      s1_prs2_d     = i_issue_prs2;
      s1_prd_d      = i_issue_prd;
      s1_tag_d      = i_issue_rob_tag;
      s1_imm_d      = i_issue_imm;
      s1_pc_d       = i_issue_pc;
      s1_alu_op_d   = i_issue_alu_op;
      s1_alusrc_d   = i_issue_alusrc;
      s1_captured_d = 1'b0;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end else if (s1_valid_q) begin
      s1_valid_d    = !s1_killed;
      s1_captured_d = 1'b1;
      s1_rs1_d      = rs1_raw;
      s1_rs2_d      = rs2_raw;
    end
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_prd_d    = s2_prd_q;
    s2_tag_d    = s2_tag_q;
    s2_result_d = s2_result_q;
    if (s1_adv) begin
      s2_valid_d  = !s1_killed;
      s2_prd_d    = s1_prd_q;
      s2_tag_d    = s1_tag_q;
      s2_result_d = alu_result;
    end else if (s2_free) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_prs1_q     <= '0;
      s1_prs2_q     <= '0;
      s1_prd_q      <= '0;
      s1_tag_q      <= '0;
      s1_imm_q      <= 32'd0;
      s1_pc_q       <= 32'd0;
      s1_alu_op_q   <= 4'd0;
      s1_alusrc_q   <= 1'b0;
      s1_captured_q <= 1'b0;
      s1_rs1_q      <= 32'd0;
      s1_rs2_q      <= 32'd0;
      s2_valid_q    <= 1'b0;
      s2_prd_q      <= '0;
      s2_tag_q      <= '0;
      s2_result_q   <= 32'd0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_prs1_q     <= s1_prs1_d;
      s1_prs2_q     <= s1_prs2_d;
      s1_prd_q      <= s1_prd_d;
      s1_tag_q      <= s1_tag_d;
      s1_imm_q      <= s1_imm_d;
      s1_pc_q       <= s1_pc_d;
      s1_alu_op_q   <= s1_alu_op_d;
      s1_alusrc_q   <= s1_alusrc_d;
      s1_captured_q <= s1_captured_d;
      s1_rs1_q      <= s1_rs1_d;
      s1_rs2_q      <= s1_rs2_d;
      s2_valid_q    <= s2_valid_d;
      s2_prd_q      <= s2_prd_d;
      s2_tag_q      <= s2_tag_d;
      s2_result_q   <= s2_result_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit with a synchronous-read register file model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_issue_valid;
  logic [6:0]  i_issue_prs1, i_issue_prs2, i_issue_prd;
  logic [3:0]  i_issue_rob_tag;
  logic [31:0] i_issue_imm, i_issue_pc;
  logic [3:0]  i_issue_alu_op;
  logic        i_issue_alusrc;
  logic        o_eu_ready;
  logic [6:0]  o_rf_raddr1, o_rf_raddr2;
  logic [31:0] i_rf_rdata1, i_rf_rdata2;
  logic        o_cdb_req;
  logic [6:0]  o_cdb_prd;
  logic [3:0]  o_cdb_rob_tag;
  logic [31:0] o_cdb_data;
  logic        i_cdb_grant;
  logic        branch_mispredict;
  logic [3:0]  mispredict_rob_tag;
  logic [3:0]  i_rob_head;

  int errors = 0;
  int checks = 0;

  logic [31:0] rf [0:127];

  typedef struct {
    logic [6:0]  prs1;
    logic [6:0]  prs2;
    logic [6:0]  prd;
    logic [3:0]  op;
    logic        alusrc;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [12];

  alu_exec_unit #(.PREG_WIDTH(7), .ROB_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .i_issue_valid(i_issue_valid), .i_issue_prs1(i_issue_prs1), .i_issue_prs2(i_issue_prs2),
    .i_issue_prd(i_issue_prd), .i_issue_rob_tag(i_issue_rob_tag), .i_issue_imm(i_issue_imm),
    .i_issue_pc(i_issue_pc), .i_issue_alu_op(i_issue_alu_op), .i_issue_alusrc(i_issue_alusrc),
    .o_eu_ready(o_eu_ready), .o_rf_raddr1(o_rf_raddr1), .o_rf_raddr2(o_rf_raddr2),
    .i_rf_rdata1(i_rf_rdata1), .i_rf_rdata2(i_rf_rdata2),
    .o_cdb_req(o_cdb_req), .o_cdb_prd(o_cdb_prd), .o_cdb_rob_tag(o_cdb_rob_tag),
    .o_cdb_data(o_cdb_data), .i_cdb_grant(i_cdb_grant),
    .branch_mispredict(branch_mispredict), .mispredict_rob_tag(mispredict_rob_tag),
    .i_rob_head(i_rob_head)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    i_rf_rdata1 <= rf[o_rf_raddr1];
    i_rf_rdata2 <= rf[o_rf_raddr2];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [6:0] prs1, input logic [6:0] prs2, input logic [6:0] prd,
                             input logic [3:0] tag, input logic [3:0] op, input logic alusrc,
                             input logic [31:0] imm, input logic [31:0] pc);
    i_issue_valid   = 1'b1;
    i_issue_prs1    = prs1;
    i_issue_prs2    = prs2;
    i_issue_prd     = prd;
    i_issue_rob_tag = tag;
    i_issue_alu_op  = op;
    i_issue_alusrc  = alusrc;
    i_issue_imm     = imm;
    i_issue_pc      = pc;
  endtask

  task automatic drain;
    i_issue_valid     = 1'b0;
    branch_mispredict = 1'b0;
    i_cdb_grant       = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    i_issue_prs1 = 7'h2A;
    i_issue_prs2 = 7'h15;
    tick();
    tick();
    checks++; if (o_cdb_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", o_cdb_req); end
    checks++; if (o_eu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", o_eu_ready); end
    checks++; if (o_cdb_data !== 32'd0 || o_cdb_prd !== 7'd0 || o_cdb_rob_tag !== 4'd0) begin
      errors++; $display("FAIL reset_payload: got data=%h prd=%0d tag=%0d expected all 0", o_cdb_data, o_cdb_prd, o_cdb_rob_tag);
    end
    checks++; if (o_rf_raddr1 !== 7'h2A || o_rf_raddr2 !== 7'h15) begin
      errors++; $display("FAIL reset_raddr: got %h/%h expected 2a/15", o_rf_raddr1, o_rf_raddr2);
    end
    reset = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_back_to_back;
    rf[5] = 32'd10; rf[6] = 32'd50; rf[7] = 32'd8;
    i_cdb_grant = 1'b1;
    i_rob_head  = 4'd0;
    drive_issue(7'd5, 7'd0, 7'd9, 4'd3, 4'd0, 1'b1, 32'd7, 32'd0);
    #1;
    checks++; if (o_eu_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %b expected 1", o_eu_ready); end
    tick();
    drive_issue(7'd6, 7'd7, 7'd10, 4'd4, 4'd1, 1'b0, 32'd0, 32'd0);
    #1;
    checks++; if (o_eu_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b expected 1", o_eu_ready); end
    tick();
    i_issue_valid = 1'b0;
    #1;
    checks++; if (o_cdb_req !== 1'b1 || o_cdb_data !== 32'd17 || o_cdb_prd !== 7'd9 || o_cdb_rob_tag !== 4'd3) begin
      errors++; $display("FAIL b2b_first: got req=%b data=%0d prd=%0d tag=%0d expected 1/17/9/3", o_cdb_req, o_cdb_data, o_cdb_prd, o_cdb_rob_tag);
    end
    tick();
    checks++; if (o_cdb_req !== 1'b1 || o_cdb_data !== 32'd42 || o_cdb_prd !== 7'd10 || o_cdb_rob_tag !== 4'd4) begin
      errors++; $display("FAIL b2b_second: got req=%b data=%0d prd=%0d tag=%0d expected 1/42/10/4", o_cdb_req, o_cdb_data, o_cdb_prd, o_cdb_rob_tag);
    end
    tick();
    checks++; if (o_cdb_req !== 1'b0) begin errors++; $display("FAIL b2b_empty: got req=%b expected 0", o_cdb_req); end
    $display("test_back_to_back done");
  endtask

  task automatic test_stall;
    logic [31:0] seen [2];
    int n;
    n = 0;
    seen[0] = 32'd0; seen[1] = 32'd0;
    rf[1] = 32'd100; rf[2] = 32'd5; rf[3] = 32'h0000F0F0; rf[4] = 32'h00000FF0;
    i_cdb_grant = 1'b0;
    drive_issue(7'd1, 7'd2, 7'd11, 4'd5, 4'd0, 1'b0, 32'd0, 32'd0);
    tick();
    drive_issue(7'd3, 7'd4, 7'd12, 4'd6, 4'd4, 1'b0, 32'd0, 32'd0);
    #1;
    checks++; if (o_eu_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_fill: got %b expected 1", o_eu_ready); end
    tick();
    i_issue_valid = 1'b0;
    rf[3] = 32'h11111111;
    rf[4] = 32'h22222222;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (o_cdb_req !== 1'b1 || o_cdb_data !== 32'd105) begin
        errors++; $display("FAIL stall_hold%0d: got req=%b data=%h expected 1/00000069", k, o_cdb_req, o_cdb_data);
      end
      checks++; if (o_eu_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %b expected 0", k, o_eu_ready); end
      tick();
    end
    i_cdb_grant = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (o_cdb_req === 1'b1) begin
        if (n < 2) seen[n] = o_cdb_data;
        n++;
      end
      tick();
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL stall_count: got %0d broadcasts expected 2", n); end
    checks++; if (seen[0] !== 32'd105) begin errors++; $display("FAIL stall_data0: got %h expected 00000069", seen[0]); end
    checks++; if (seen[1] !== 32'h0000FF00) begin errors++; $display("FAIL stall_data1: got %h expected 0000ff00", seen[1]); end
    $display("test_stall done");
  endtask

  task automatic test_alu;
    rf[0] = 32'h55; rf[13] = 32'h80000000; rf[14] = 32'hFFFFFFFF; rf[15] = 32'd3; rf[16] = 32'd5;
    vecs[0]  = '{7'd13, 7'd0,  7'd20, 4'd7,  1'b1, 32'd4,          32'd0,     32'hF8000000};
    vecs[1]  = '{7'd14, 7'd0,  7'd21, 4'd8,  1'b1, 32'd1,          32'd0,     32'd1};
    vecs[2]  = '{7'd14, 7'd0,  7'd22, 4'd9,  1'b1, 32'd1,          32'd0,     32'd0};
    vecs[3]  = '{7'd0,  7'd0,  7'd23, 4'd11, 1'b1, 32'h2000,       32'h100,   32'h2100};
    vecs[4]  = '{7'd0,  7'd0,  7'd24, 4'd12, 1'b1, 32'd0,          32'h100,   32'h104};
    vecs[5]  = '{7'd0,  7'd0,  7'd25, 4'd10, 1'b1, 32'hABCDE000,   32'd0,     32'hABCDE000};
    vecs[6]  = '{7'd15, 7'd16, 7'd26, 4'd1,  1'b0, 32'd0,          32'd0,     32'hFFFFFFFE};
    vecs[7]  = '{7'd0,  7'd0,  7'd0,  4'd0,  1'b1, 32'd3,          32'd0,     32'd3};
    vecs[8]  = '{7'd13, 7'd0,  7'd27, 4'd14, 1'b1, 32'd5,          32'd0,     32'd0};
    vecs[9]  = '{7'd15, 7'd0,  7'd28, 4'd5,  1'b1, 32'h21,         32'd0,     32'd6};
    vecs[10] = '{7'd13, 7'd0,  7'd29, 4'd6,  1'b1, 32'd4,          32'd0,     32'h08000000};
    vecs[11] = '{7'd15, 7'd16, 7'd30, 4'd3,  1'b0, 32'd0,          32'd0,     32'd7};
    i_cdb_grant = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive_issue(vecs[i].prs1, vecs[i].prs2, vecs[i].prd, i[3:0], vecs[i].op, vecs[i].alusrc, vecs[i].imm, vecs[i].pc);
      tick();
      i_issue_valid = 1'b0;
      tick();
      checks++; if (o_cdb_req !== 1'b1 || o_cdb_data !== vecs[i].exp || o_cdb_prd !== vecs[i].prd) begin
        errors++; $display("FAIL alu_vec%0d: got req=%b data=%h prd=%0d expected 1/%h/%0d", i, o_cdb_req, o_cdb_data, o_cdb_prd, vecs[i].exp, vecs[i].prd);
      end
      tick();
    end
    $display("test_alu done");
  endtask

  task automatic test_wrap_flush;
    i_rob_head = 4'd14;
    i_cdb_grant = 1'b0;
    drive_issue(7'd0, 7'd0, 7'd40, 4'd1, 4'd0, 1'b1, 32'd1, 32'd0);
    tick();
    drive_issue(7'd0, 7'd0, 7'd41, 4'd14, 4'd0, 1'b1, 32'd2, 32'd0);
    tick();
    i_issue_valid = 1'b0;
    #1;
    checks++; if (o_cdb_req !== 1'b1 || o_cdb_rob_tag !== 4'd1) begin
      errors++; $display("FAIL wrap_pre: got req=%b tag=%0d expected 1/1", o_cdb_req, o_cdb_rob_tag);
    end
    branch_mispredict = 1'b1;
    mispredict_rob_tag = 4'd15;
    #1;
    checks++; if (o_cdb_req !== 1'b0) begin errors++; $display("FAIL wrap_kill_req: got %b expected 0", o_cdb_req); end
    checks++; if (o_eu_ready !== 1'b1) begin errors++; $display("FAIL wrap_kill_ready: got %b expected 1", o_eu_ready); end
    tick();
    branch_mispredict = 1'b0;
    i_cdb_grant = 1'b1;
    #1;
    checks++; if (o_cdb_req !== 1'b1 || o_cdb_rob_tag !== 4'd14 || o_cdb_data !== 32'd2) begin
      errors++; $display("FAIL wrap_older: got req=%b tag=%0d data=%h expected 1/14/00000002", o_cdb_req, o_cdb_rob_tag, o_cdb_data);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (o_cdb_req !== 1'b0) begin errors++; $display("FAIL wrap_after%0d: got req=%b tag=%0d expected req 0", k, o_cdb_req, o_cdb_rob_tag); end
    end
    $display("test_wrap_flush done");
  endtask

  task automatic test_flush_issue;
    i_rob_head = 4'd2;
    i_cdb_grant = 1'b1;
    branch_mispredict = 1'b1;
    mispredict_rob_tag = 4'd4;
    drive_issue(7'd0, 7'd0, 7'd42, 4'd4, 4'd0, 1'b1, 32'h44, 32'd0);
    #1;
    checks++; if (o_eu_ready !== 1'b1) begin errors++; $display("FAIL flush_branch_ready: got %b expected 1", o_eu_ready); end
    tick();
    branch_mispredict = 1'b0;
    i_issue_valid = 1'b0;
    tick();
    checks++; if (o_cdb_req !== 1'b1 || o_cdb_rob_tag !== 4'd4 || o_cdb_data !== 32'h44) begin
      errors++; $display("FAIL flush_branch_bcast: got req=%b tag=%0d data=%h expected 1/4/00000044", o_cdb_req, o_cdb_rob_tag, o_cdb_data);
    end
    tick();
    branch_mispredict = 1'b1;
    drive_issue(7'd0, 7'd0, 7'd43, 4'd6, 4'd0, 1'b1, 32'h66, 32'd0);
    #1;
    checks++; if (o_eu_ready !== 1'b1) begin errors++; $display("FAIL flush_young_ready: got %b expected 1", o_eu_ready); end
    tick();
    branch_mispredict = 1'b0;
    i_issue_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (o_cdb_req !== 1'b0) begin errors++; $display("FAIL flush_young_gone%0d: got req=%b tag=%0d expected req 0", k, o_cdb_req, o_cdb_rob_tag); end
      tick();
    end
    $display("test_flush_issue done");
  endtask

  task automatic test_mid_reset;
    i_rob_head = 4'd0;
    i_cdb_grant = 1'b0;
    drive_issue(7'd0, 7'd0, 7'd44, 4'd7, 4'd0, 1'b1, 32'h77, 32'd0);
    tick();
    drive_issue(7'd0, 7'd0, 7'd45, 4'd8, 4'd0, 1'b1, 32'h88, 32'd0);
    tick();
    i_issue_valid = 1'b0;
    #1;
    checks++; if (o_cdb_req !== 1'b1 || o_eu_ready !== 1'b0) begin
      errors++; $display("FAIL mreset_full: got req=%b ready=%b expected 1/0", o_cdb_req, o_eu_ready);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (o_cdb_req !== 1'b0 || o_eu_ready !== 1'b1) begin
      errors++; $display("FAIL mreset_after: got req=%b ready=%b expected 0/1", o_cdb_req, o_eu_ready);
    end
    checks++; if (o_cdb_data !== 32'd0) begin errors++; $display("FAIL mreset_data: got %h expected 00000000", o_cdb_data); end
    i_cdb_grant = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (o_cdb_req !== 1'b0) begin errors++; $display("FAIL mreset_stale%0d: got req=%b data=%h expected req 0", k, o_cdb_req, o_cdb_data); end
    end
    $display("test_mid_reset done");
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rf[i] = 32'd0;
    reset = 1'b1;
    i_issue_valid = 1'b0;
    i_issue_prs1 = 7'd0; i_issue_prs2 = 7'd0; i_issue_prd = 7'd0;
    i_issue_rob_tag = 4'd0; i_issue_imm = 32'd0; i_issue_pc = 32'd0;
    i_issue_alu_op = 4'd0; i_issue_alusrc = 1'b0;
    i_cdb_grant = 1'b0;
    branch_mispredict = 1'b0;
    mispredict_rob_tag = 4'd0;
    i_rob_head = 4'd0;
    test_reset();
    test_back_to_back();
    drain();
    test_stall();
    drain();
    test_alu();
    drain();
    test_wrap_flush();
    drain();
    test_flush_issue();
    drain();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Two-stage integer execution unit directly downstream of the reservation station. It accepts one issued micro-op per cycle, reads both source operands from the physical register file, and computes the ALU result. It then holds that result on the common data bus (CDB) request lines until the CDB arbiter grants it. The unit applies back-pressure to the reservation station through `o_eu_ready` and kills wrong-path work on branch mispredict.

## Interface
- `PREG_WIDTH`, 7, physical register index width
- `ROB_WIDTH`, 4, ROB tag width; tags wrap modulo 2^ROB_WIDTH
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `i_issue_valid` in 1: RS presents an op
- `i_issue_prs1`, `i_issue_prs2`, `i_issue_prd` in PREG_WIDTH: sources, destination
- `i_issue_rob_tag` in ROB_WIDTH: op's ROB tag
- `i_issue_imm`, `i_issue_pc` in 32: immediate, PC
- `i_issue_alu_op` in 4: operation select
- `i_issue_alusrc` in 1: 1 = operand B is imm
- `o_eu_ready` out 1: op accepted this cycle when `i_issue_valid & o_eu_ready`
- `o_rf_raddr1`, `o_rf_raddr2` out PREG_WIDTH: register file read addresses
- `i_rf_rdata1`, `i_rf_rdata2` in 32: synchronous read data, valid the cycle after the address
- `o_cdb_req` out 1: result waiting for broadcast
- `o_cdb_prd` out PREG_WIDTH, `o_cdb_rob_tag` out ROB_WIDTH, `o_cdb_data` out 32: broadcast payload
- `i_cdb_grant` in 1: arbiter accepts the payload this cycle
- `branch_mispredict` in 1: flush younger ops
- `mispredict_rob_tag` in ROB_WIDTH: tag of the mispredicting branch
- `i_rob_head` in ROB_WIDTH: current ROB head, used for age comparison

## Operation
- **Stage S1 (register read).** Holds the op plus two 32-bit operand holding registers and a `captured` flag.
  - `o_rf_raddr1/2` = `i_issue_prs1/2` combinationally.
  - On the first cycle an op is in S1, use `i_rf_rdata1/2` directly and latch them into the holding registers.
  - If S1 stalls, later cycles use the holding registers. The operands must not be re-read.
- **Stage S2 (execute/broadcast).** Computes the result on entry into S2 and registers it.
  - Payload holds stable while `o_cdb_req=1` and `i_cdb_grant=0`.
- **Operand selection.**
  - A = rs1 data. Register index 0 reads as 0.
  - B = `alusrc` ? imm : rs2 data.
- **ALU op encoding.**
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA: shift amount B[4:0]
  - 8 SLT (signed, result 0/1), 9 SLTU (unsigned, result 0/1)
  - 10 LUI: result = imm
  - 11 AUIPC: result = pc+imm
  - 12 LINK: result = pc+4
  - 13–15: result = 0
- **Arithmetic.** All arithmetic is 32-bit modulo 2^32.
- **Advance and ready.**
  - `s2_free` = !s2_valid | i_cdb_grant | s2_killed.
  - `s1_adv` = s1_valid & s2_free.
  - `o_eu_ready` = !s1_valid | s1_adv. This is a combinational path from `i_cdb_grant`.
- **Age rule.** An op is younger than the branch when ((tag − i_rob_head) mod 2^W) > ((mispredict_rob_tag − i_rob_head) mod 2^W).
- **Flush.** While `branch_mispredict`=1:
  - Younger ops in S1 and S2 are invalidated at the clock edge.
  - A younger incoming issue is acknowledged (`o_eu_ready` unchanged) but discarded.
  - Non-younger ops, including the branch itself, proceed normally.
- **No wrong-path broadcast.** `o_cdb_req` = s2_valid & !(branch_mispredict & younger(s2)), so a killed op never broadcasts, even if granted that same cycle.
- **Destination x0.** `prd`=0 still broadcasts, so the ROB completes the op.

## Timing
- **Reset.** All valids 0.
  - `o_cdb_req`=0; `o_eu_ready`=1.
  - `o_rf_raddr*` follow the inputs.
  - `o_cdb_prd`/`o_cdb_rob_tag`/`o_cdb_data` = 0.
  - Reset during a stall drops all in-flight ops.
- **Latency.** Issue accepted at cycle T:
  - T+1: op in S1, rf data arrives.
  - T+2: `o_cdb_req`=1 with result.
  - If granted in T+2, the entry is gone at T+3.
- **Throughput.** One op per cycle while grants are continuous.
- **Register file visibility.** A register file write performed at the edge closing cycle T−1 must be visible to a read addressed in T. No internal bypass.
- **Back-pressure.** With S2 blocked (no grant), S1 holds and `o_eu_ready`=0 once S1 is full; no op is lost or duplicated.
- **Simultaneous grant + new S1 op.** S2 is replaced in the same edge; no bubble.
- **Simultaneous flush + grant on a non-younger S2.** Broadcast occurs and S2 advances normally.

## Test plan
1. **Back-to-back ADD.** Issue ADD prs1=5 (rf=10), alusrc=1, imm=7, prd=9, tag=3, grant tied 1 -> T+2: req=1, data=17, prd=9, tag=3. A second op issued at T+1 broadcasts at T+3.
2. **Stall with operand hold.** Hold grant=0 for 4 cycles, change rf data after T+1 -> `o_eu_ready`=0 once S1 is full; broadcast data uses the originally read values. Exactly two broadcasts occur after grant returns.
3. **ALU coverage.** SRA 0x80000000 by 4 -> 0xF8000000. SLT −1<1 -> 1. SLTU 0xFFFFFFFF<1 -> 0. AUIPC pc=0x100, imm=0x2000 -> 0x2100. LINK pc=0x100 -> 0x104.
4. **Wrap-around flush.** head=14, branch tag=15. S2 tag=1 (younger), S1 tag=14 (older) -> req drops the same cycle. The tag=14 op still broadcasts. The tag=1 op never appears on the CDB.
5. **Flush with concurrent issue.** Mispredict tag=4 while issuing tag=4 (the branch) -> the branch op is accepted and broadcast. Repeated with issuing tag=6 -> that op is discarded, no broadcast.
6. **Mid-stall reset.** Reset asserted with both stages valid and grant=0 -> next cycle req=0, `o_eu_ready`=1, and no stale broadcast afterwards.
